// File: rtl/board_link_tx_if.sv
// rtl/board_link_tx_if.sv - signal bundle between board_link_tx and its environment
//
// Purpose: groups the link pins, the board cell-memory read port and the Top
// status handshake so they travel as one port.
//   link   : request, ack_in (from remote), ack_out, data[3:0], valid (to remote)
//   memory : cell_addr[6:0], cell_rd (to memory), cell_din[3:0] (from memory)
//   control: enable (from Top), busy, done, error (to Top)
// Modports: master = the transmitter, slave = everything around it.

interface board_link_tx_if;
  logic       request;
  logic       ack_in;
  logic       ack_out;
  logic [3:0] data;
  logic       valid;
  logic [6:0] cell_addr;
  logic       cell_rd;
  logic [3:0] cell_din;
  logic       enable;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    input  request, ack_in, cell_din, enable,
    output ack_out, data, valid, cell_addr, cell_rd, busy, done, error
  );

  modport slave (
    output request, ack_in, cell_din, enable,
    input  ack_out, data, valid, cell_addr, cell_rd, busy, done, error
  );
endinterface

// File: rtl/board_link_tx.sv
// rtl/board_link_tx.sv - sender side of the inter-board link (header + 81 cells)
//
// Purpose: on a remote request sends one HEADER word followed by CELLS board
// cells (address order), one 4-bit word per 4-phase valid/ack handshake.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   bus        board_link_tx_if.master (link pins, cell memory port, Top status)
// Optional feature: define LINK_TIMEOUT_EN to abort when the remote does not
// acknowledge within TIMEOUT_CYCLES cycles.

module board_link_tx #(
  parameter int         CELLS          = 81,
  parameter logic [3:0] HEADER         = 4'hF,
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  board_link_tx_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_HDR,
    S_FETCH,
    S_CAPTURE,
    S_DRIVE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  localparam logic [6:0] LAST_ADDR = 7'(CELLS - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_req_sync;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_req_s;
  logic                   w_ack_s;

  logic [3:0] r_data,    w_data_nxt;
  logic       r_valid,   w_valid_nxt;
  logic       r_ack_out, w_ack_out_nxt;
  logic       r_busy,    w_busy_nxt;
  logic       r_done,    w_done_nxt;
  logic       r_error,   w_error_nxt;
  logic [6:0] r_cnt,     w_cnt_nxt;
  logic       r_hdr,     w_hdr_nxt;   // the word in flight is the header

  logic       w_in_xfer;
  logic       w_timeout;
  logic       w_start_ok;

  // request and ack_in come from another board's clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_sync <= '0;
      r_ack_sync <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], bus.request};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.ack_in};
    end
  end

  assign w_req_s = r_req_sync[SYNC_STAGES-1];
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

`ifdef LINK_TIMEOUT_EN
  localparam logic [19:0] WAIT_LAST = 20'(TIMEOUT_CYCLES - 1);

  logic [19:0] r_wait_cnt;
  logic        r_armed;     // request has been seen low in IDLE since the last timeout
  logic        w_in_wait;

  assign w_in_wait  = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);
  assign w_timeout  = w_in_wait && (r_wait_cnt == WAIT_LAST);
  assign w_start_ok = r_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_armed    <= 1'b0;
    end else begin
      // Any state change clears, which covers entry into both wait states.
      if (w_state_nxt != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_in_wait) begin
        r_wait_cnt <= r_wait_cnt + 20'd1;
      end
      if (w_timeout) begin
        r_armed <= 1'b0;
      end else if ((r_state == S_IDLE) && !w_req_s) begin
        r_armed <= 1'b1;
      end
    end
  end
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign w_start_ok       = 1'b1;
`endif

  assign w_in_xfer = (r_state == S_LOAD_HDR) || (r_state == S_FETCH)  ||
                     (r_state == S_CAPTURE)  || (r_state == S_DRIVE)  ||
                     (r_state == S_WAIT_HI)  || (r_state == S_WAIT_LO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ack_out <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_cnt     <= '0;
      r_hdr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ack_out <= w_ack_out_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hdr     <= w_hdr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_ack_out_nxt = r_ack_out;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_hdr_nxt     = r_hdr;

    // Abort is checked ahead of the state handling so it beats a
    // simultaneous ack in WAIT_HI.
    if (w_in_xfer && (!w_req_s || !bus.enable || w_timeout)) begin
      w_state_nxt = S_IDLE;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_error_nxt = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_valid_nxt   = 1'b0;
          w_ack_out_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          // ack must be low so a stale ack cannot complete the header
          if (w_req_s && bus.enable && !w_ack_s && w_start_ok) begin
            w_state_nxt = S_LOAD_HDR;
          end
        end
        S_LOAD_HDR: begin
          w_data_nxt  = HEADER;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_hdr_nxt   = 1'b1;
          w_state_nxt = S_DRIVE;
        end
        S_FETCH: begin
          w_state_nxt = S_CAPTURE;
        end
        S_CAPTURE: begin
          w_data_nxt  = bus.cell_din;
          w_state_nxt = S_DRIVE;
        end
        S_DRIVE: begin
          // data settled during the previous cycle; only now raise valid
          w_valid_nxt = 1'b1;
          w_state_nxt = S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (w_ack_s) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!w_ack_s) begin
            if (r_hdr) begin
              w_hdr_nxt   = 1'b0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_FETCH;
            end else if (r_cnt == LAST_ADDR) begin
              w_ack_out_nxt = 1'b1;
              w_busy_nxt    = 1'b0;
              w_done_nxt    = 1'b1;
              w_state_nxt   = S_DONE;
            end else begin
              w_cnt_nxt   = r_cnt + 7'd1;
              w_state_nxt = S_FETCH;
            end
          end
        end
        S_DONE: begin
          // hold the completion flag until the remote withdraws its request
          if (!w_req_s) begin
            w_ack_out_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.cell_rd   = (r_state == S_FETCH);
  assign bus.cell_addr = (r_state == S_FETCH) ? r_cnt : 7'd0;
  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.ack_out   = r_ack_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;

endmodule

// File: doc/board_link_tx.md
Name: board_link_tx

Overview:
- Sender-side controller for the inter-board link (request / ack_in / ack_out / data / valid).
- On a remote request it sequences one header word, then the 81 sudoku cells, one 4-bit word per 4-phase handshake.
- Cells are read from the local board cell memory.
- Sits between the Top menu/game FSM (start/busy/done status) and the board pins.

Parameters:
- CELLS, 81, number of cell words sent after the header.
- HEADER, 4'hF, value of word 0.
- SYNC_STAGES, 2, flop stages on request and ack_in (allowed range 2..3).
- TIMEOUT_CYCLES, 1000000, ack wait limit; used only with LINK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- request  in  1  remote board asks for a transfer; level signal, asynchronous.
- ack_in  in  1  remote acknowledge of the current word; asynchronous.
- ack_out  out  1  transfer-complete flag to the remote board.
- data  out  4  current word on the link.
- valid  out  1  data is stable and must be accepted.
- cell_addr  out  7  board memory read address, 0..CELLS-1.
- cell_rd  out  1  read strobe; cell_din is valid exactly 1 cycle after cell_rd.
- cell_din  in  4  board memory read data.
- enable  in  1  Top permits transfers (high only in SGAME).
- busy  out  1  transfer in progress; Top freezes board edits while busy is high.
- done  out  1  one-cycle pulse when the full transfer completes.
- error  out  1  one-cycle pulse when a transfer aborts.

Behaviour:
- Reset: all outputs 0, state IDLE, word counter 0, synchronizer flops 0.
- Synchronization: request and ack_in pass through SYNC_STAGES flops. All decisions below use the synchronized values req_s and ack_s.
- IDLE:
  - valid = 0, ack_out = 0, busy = 0.
  - If req_s = 1, enable = 1 and ack_s = 0: go to LOAD_HDR.
  - Request while enable = 0 is ignored and no response is given.
- LOAD_HDR: data <= HEADER, counter <= 0, busy <= 1. Next state is DRIVE.
- FETCH: cell_rd = 1 and cell_addr = counter for exactly 1 cycle. Next state is CAPTURE.
- CAPTURE: data <= cell_din. Next state is DRIVE.
- DRIVE: valid <= 1. Next state is WAIT_HI.
  - data is registered and stable for at least 1 cycle before valid rises.
  - data and valid are registered outputs.
- WAIT_HI:
  - Hold data and valid until ack_s = 1.
  - Then valid <= 0 and go to WAIT_LO.
- WAIT_LO: wait for ack_s = 0, then:
  - If the header was just sent: go to FETCH with counter = 0.
  - Else if counter = CELLS-1: go to DONE.
  - Else: counter <= counter + 1 and go to FETCH.
- DONE:
  - ack_out <= 1, busy <= 0, done pulses on entry.
  - Stay in DONE until req_s = 0.
  - Then ack_out <= 0 and go to IDLE; a new transfer starts only after request has fallen.
- Word count: exactly 1 + CELLS valid pulses per transfer. Cells are sent in address order 0..80 and cell_addr never exceeds CELLS-1.
- Abort on req_s falling in any state from LOAD_HDR through WAIT_LO:
  - Next cycle: valid = 0, busy = 0, error pulse, go to IDLE.
  - No ack_out is given.
- Abort on enable falling mid-transfer: same handling as the request-drop abort.
- Simultaneous req_s = 0 and ack_s = 1 in WAIT_HI: the abort wins.
- Reset mid-transfer returns to the reset values on the next edge with no error pulse. valid drops within 1 cycle.
- Counter is 7 bits and does not wrap within a transfer.

Optional Feature:
- Macro: LINK_TIMEOUT_EN.
- When defined:
  - A 20-bit wait counter clears on entry to WAIT_HI and on entry to WAIT_LO.
  - It increments every cycle spent in those states.
  - On reaching TIMEOUT_CYCLES-1: valid = 0, error pulse, go to IDLE without ack_out.
  - A new transfer then needs req_s to fall and rise again (the request must be seen low once in IDLE).
- When not defined: no counter; WAIT_HI and WAIT_LO wait indefinitely.

Test Plan:
- Full transfer: memory[i] = i mod 10, enable = 1, remote model acks each valid after 3 cycles.
  - Required: 82 words captured, first 4'hF, then 0,1,…,9,0,…,0 (cell 80 = 0).
  - done pulses once; ack_out stays high until request drops, then returns to 0.
- Disabled: enable = 0, raise request.
  - Required: valid, busy and ack_out stay 0 for 200 cycles.
- Mid abort: drop request after word 40 is acknowledged.
  - Required: valid low within SYNC_STAGES+1 cycles, error pulses once, no ack_out.
  - A re-request restarts from the HEADER word.
- Handshake ordering: ack_in held high when valid rises in the next word.
  - Required: no new valid until ack_in has been seen low.
  - cell_rd is issued exactly 81 times, once per address 0..80.
- Reset in WAIT_HI during word 10.
  - Required: next cycle all outputs 0, state IDLE, no error pulse.
- LINK_TIMEOUT_EN with TIMEOUT_CYCLES = 50: remote never acks.
  - Required: valid drops and error pulses 50 cycles after valid rose.
  - No restart until request toggles low then high.
